fx_sequencer: RTL and testbench
===============================

FX_SEQUENCER -- requirements
Module: fx_sequencer

Interface
REQ-001 SHALL have parameter NUM_FX, default 4: number of effect slots in the chain, range 1..8.
REQ-002 SHALL have parameter SLOT_GAP, default 2: idle cycles after each slot update for the slot output to settle, range 0..15.
REQ-003 SHALL have parameter DEBOUNCE, default 1000: cycles a button must be stably high to register one press, minimum 2.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe marking a new ADC sample.
REQ-007 SHALL have port btn  input  NUM_FX  raw footswitch levels, already synchronized, one bit per slot.
REQ-008 SHALL have port fx_update  output  NUM_FX  one-hot, one-cycle update strobe per slot.
REQ-009 SHALL have port fx_toggle_en  output  NUM_FX  one-cycle toggle strobes to the slot enable flops.
REQ-010 SHALL have port fx_enabled  output  NUM_FX  mirror of each slot's enable state.
REQ-011 SHALL have port dac_valid  output  1  one-cycle strobe: the chain output is settled for the DAC.
REQ-012 SHALL have port busy  output  1  high while a sample is propagating through the chain.
REQ-013 SHALL have port overrun  output  1  one-cycle strobe: a sample_valid was dropped.

Function
REQ-014 SHALL implement the FSM states IDLE, UPD (slot k update), GAP (settle count), and DONE.
REQ-015 IDLE with sample_valid=1 SHALL go to UPD with k=0; sample_valid in IDLE is accepted regardless of pending toggles.
REQ-016 In UPD, fx_update[k] SHALL be 1 for exactly one cycle, with all other bits 0.
REQ-017 From UPD, the FSM SHALL enter GAP for SLOT_GAP cycles, or skip GAP when SLOT_GAP=0.
REQ-018 After the update and settle of slot k, the FSM SHALL go to UPD with k+1 when k<NUM_FX-1, otherwise to DONE.
REQ-019 DONE SHALL last one cycle with dac_valid=1 and then return to IDLE.
REQ-020 Timing for sample_valid at cycle t: fx_update[k] SHALL be high at t+1+k*(SLOT_GAP+1), and dac_valid SHALL be high at t+1+NUM_FX*(SLOT_GAP+1).
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 sample_valid in any state other than IDLE SHALL be dropped, and overrun SHALL be 1 in the following cycle; the sequence in progress is unaffected.
REQ-023 Each button SHALL have a saturating counter of width clog2(DEBOUNCE+1).
REQ-024 While btn[i]=1, counter i SHALL increment, saturating at DEBOUNCE; btn[i]=0 SHALL clear it.
REQ-025 On the edge where counter i becomes DEBOUNCE, pending[i] SHALL be set, giving one press per hold; a glitch shorter than DEBOUNCE cycles SHALL produce nothing.
REQ-026 In a cycle where state=IDLE, sample_valid=0 and pending!=0, the block SHALL on the next cycle assert fx_toggle_en=pending for one cycle, invert the matching fx_enabled bits, and clear those pending bits.
REQ-027 A pending bit set in the same cycle as an issue SHALL be retained for the next issue.
REQ-028 Toggles SHALL never be issued while busy=1, so an effect never changes enable mid-sample.
REQ-029 A second debounced press of the same slot while its bit is still pending SHALL be absorbed, so there is one toggle, not two.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL set: state=IDLE, k=0, GAP counter=0, all debounce counters=0, pending=0.
REQ-032 While reset=1 at a clock edge, the block SHALL set: fx_update=0, fx_toggle_en=0, fx_enabled=0, dac_valid=0, busy=0, overrun=0.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no dac_valid; the first cycle after reset SHALL accept sample_valid.

Verification
REQ-034 Scenario (NUM_FX=4, SLOT_GAP=2): sample_valid at cycle 10 -> fx_update bit 0 high at cycle 11, bit 1 at 14, bit 2 at 17, bit 3 at 20; dac_valid at 23; busy high 11..23; low at 24.
REQ-035 Scenario (same parameters): second sample_valid at cycle 15 -> overrun=1 at cycle 16; update timing unchanged; dac_valid only at 23.
REQ-036 Scenario (DEBOUNCE=8): btn[2] high from cycle 0 for 20 cycles with no samples -> pending[2] set at the edge ending cycle 7, fx_toggle_en=4'b0100 at cycle 9, fx_enabled[2]=1; a hold to cycle 20 produces no second toggle.
REQ-038 Scenario (DEBOUNCE=8): btn[0] pulses high for 7 cycles, low 1, high 7 -> no toggle ever.
REQ-039 Scenario: debounced press of btn[1] completes at cycle 12 during a sample started at cycle 10 -> no fx_toggle_en until the cycle after the first IDLE cycle with sample_valid=0 (cycle 25), then 4'b0010.
REQ-040 Scenario: reset=1 at cycle 16 during a sample started at cycle 10 -> at cycle 17 busy=0 and fx_enabled=0; no dac_valid; sample_valid at 17 -> fx_update bit 0 at 18.

Source files
------------

// File: rtl/fx_sequencer.sv
// rtl/fx_sequencer.sv - per-sample effect-chain update sequencer with debounced footswitch toggles
module fx_sequencer #(
  parameter int NUM_FX   = 4,
  parameter int SLOT_GAP = 2,
  parameter int DEBOUNCE = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [NUM_FX-1:0] btn,
  output logic [NUM_FX-1:0] fx_update,
  output logic [NUM_FX-1:0] fx_toggle_en,
  output logic [NUM_FX-1:0] fx_enabled,
  output logic              dac_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int KW = (NUM_FX > 1) ? $clog2(NUM_FX) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [KW-1:0]     K_LAST   = KW'(NUM_FX - 1);
  localparam logic [3:0]        GAP_LAST = (SLOT_GAP > 0) ? 4'(SLOT_GAP - 1) : 4'd0;
  localparam logic [CW-1:0]     CNT_MAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0]     CNT_ARM  = CW'(DEBOUNCE - 1);
  localparam logic [NUM_FX-1:0] SLOT0    = NUM_FX'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [3:0]        gap_cnt;
  logic [CW-1:0]     db_cnt [NUM_FX];
  logic [NUM_FX-1:0] pending;
  logic [NUM_FX-1:0] press;
  logic              issue;
  logic              slot_done;

  // A press fires only on the cycle its counter climbs onto DEBOUNCE, so a long hold yields one press.
  always_comb begin
    press = '0;
    for (int i = 0; i < NUM_FX; i++) begin
      press[i] = btn[i] && (db_cnt[i] == CNT_ARM);
    end
  end

  // Toggles go out only from an idle cycle that is not also starting a sample.
  always_comb begin
    issue     = 1'b0;
    slot_done = 1'b0;
    issue     = (state == IDLE) && !sample_valid && (pending != '0);
    slot_done = ((state == UPD) && (SLOT_GAP == 0)) ||
                ((state == GAP) && (gap_cnt == GAP_LAST));
  end

  // Per-button saturating debounce counters; any low level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_FX; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FX; i++) begin
        if (!btn[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != CNT_MAX) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pending presses are held until an idle gap, then issued together and folded into the enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      fx_toggle_en <= '0;
      fx_enabled   <= '0;
    end else begin
      fx_toggle_en <= issue ? pending : '0;
      if (issue) begin
        fx_enabled <= fx_enabled ^ pending;
      end
      pending <= (issue ? '0 : pending) | press;
    end
  end

  // Slot-walk FSM: update each slot in turn, wait out its settle gap, then flag the DAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      gap_cnt   <= '0;
      fx_update <= '0;
      dac_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      fx_update <= '0;
      dac_valid <= 1'b0;
      overrun   <= (state != IDLE) && sample_valid;
      if (slot_done) begin
        if (k == K_LAST) begin
          state     <= DONE;
          dac_valid <= 1'b1;
        end else begin
          k         <= k + 1'b1;
          state     <= UPD;
          fx_update <= SLOT0 << (k + 1'b1);
        end
      end else begin
        case (state)
          IDLE: begin
            if (sample_valid) begin
              state     <= UPD;
              k         <= '0;
              fx_update <= SLOT0;
              busy      <= 1'b1;
            end
          end
          UPD: begin
            state   <= GAP;
            gap_cnt <= '0;
          end
          GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fx_sequencer.sv
// tb/tb_fx_sequencer.sv - directed self-checking bench for fx_sequencer
module tb_fx_sequencer;

  logic       clk;
  logic       reset;
  logic       sample_valid;
  logic [3:0] btn;
  logic [3:0] fx_update;
  logic [3:0] fx_toggle_en;
  logic [3:0] fx_enabled;
  logic       dac_valid;
  logic       busy;
  logic       overrun;

  int n_checks;
  int n_pass;
  int cyc;

  fx_sequencer #(
    .NUM_FX  (4),
    .SLOT_GAP(2),
    .DEBOUNCE(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .btn         (btn),
    .fx_update   (fx_update),
    .fx_toggle_en(fx_toggle_en),
    .fx_enabled  (fx_enabled),
    .dac_valid   (dac_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Leaves the bench at the negedge of cycle 0 with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    sample_valid = 1'b0;
    btn          = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic run_sample(input int second);
    logic [3:0] eu;
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      cyc = c;
      eu = (c == 11) ? 4'b0001 : (c == 14) ? 4'b0010 :
           (c == 17) ? 4'b0100 : (c == 20) ? 4'b1000 : 4'b0000;
      check("fx_update", fx_update, eu);
      check("dac_valid", dac_valid, (c == 23));
      check("busy", busy, (c >= 11 && c <= 23));
      check("overrun", overrun, (second >= 0) && (c == second + 1));
      sample_valid = (c == 10) || (c == second);
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    reset        = 1'b1;
    sample_valid = 1'b0;
    btn          = 4'b0000;

    do_reset();
    check("reset_fx_update", fx_update, 4'b0000);
    check("reset_toggle", fx_toggle_en, 4'b0000);
    check("reset_enabled", fx_enabled, 4'b0000);
    check("reset_dac", dac_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_overrun", overrun, 1'b0);

    run_sample(-1);
    run_sample(15);

    // Single long hold on btn[2]: one toggle only.
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      cyc = c;
      check("hold_toggle", fx_toggle_en, (c == 9) ? 4'b0100 : 4'b0000);
      check("hold_enabled", fx_enabled, (c >= 9) ? 4'b0100 : 4'b0000);
      btn = (c < 20) ? 4'b0100 : 4'b0000;
      @(negedge clk);
    end
    btn = 4'b0000;

    // Two 7-cycle pulses on btn[0] never reach the debounce count.
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      cyc = c;
      check("glitch_toggle", fx_toggle_en, 4'b0000);
      check("glitch_enabled", fx_enabled, 4'b0000);
      btn = ((c <= 6) || (c >= 8 && c <= 14)) ? 4'b0001 : 4'b0000;
      @(negedge clk);
    end
    btn = 4'b0000;

    // Press on btn[1] lands mid-sample and waits for the idle gap.
    do_reset();
    for (int c = 0; c <= 28; c++) begin
      cyc = c;
      check("defer_toggle", fx_toggle_en, (c == 25) ? 4'b0010 : 4'b0000);
      check("defer_enabled", fx_enabled, (c >= 25) ? 4'b0010 : 4'b0000);
      check("defer_dac", dac_valid, (c == 23));
      sample_valid = (c == 10);
      btn = (c >= 5 && c <= 14) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    btn = 4'b0000;

    // Enable slot 3, start a sample, reset mid-sequence, restart right after reset.
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      logic [3:0] eu;
      cyc = c;
      eu = (c == 11 || c == 18) ? 4'b0001 : (c == 14 || c == 21) ? 4'b0010 :
           (c == 24) ? 4'b0100 : (c == 27) ? 4'b1000 : 4'b0000;
      check("abort_fx_update", fx_update, eu);
      check("abort_dac", dac_valid, (c == 30));
      check("abort_busy", busy, (c >= 11 && c <= 16) || (c >= 18 && c <= 30));
      check("abort_enabled", fx_enabled, (c >= 9 && c <= 16) ? 4'b1000 : 4'b0000);
      check("abort_toggle", fx_toggle_en, (c == 9) ? 4'b1000 : 4'b0000);
      reset        = (c == 16);
      sample_valid = (c == 10) || (c == 17);
      btn          = (c <= 7) ? 4'b1000 : 4'b0000;
      @(negedge clk);
    end
    reset        = 1'b0;
    sample_valid = 1'b0;
    btn          = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
